// File: rtl/fpu_cvt_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fpu_cvt_seq : serial IEEE-754 single <-> INT_W-bit integer converter.       |
// | Define FPU_CVT_EARLY_EN to leave SHIFT as soon as alignment completes.      |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module fpu_cvt_seq #(
  parameter int INT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  output logic        o_busy,
  output logic        o_valid,
  output logic        o_err,
  output logic [31:0] o_result,
  output logic [3:0]  o_flags
);

  typedef enum logic [2:0] {S_IDLE, S_CAPT, S_SHIFT, S_RND, S_DONE} state_t;

  localparam logic [31:0] C_MAX_S   = 32'h7FFF_FFFF >> (32 - INT_W);
  localparam logic [31:0] C_MAX_U   = 32'hFFFF_FFFF >> (32 - INT_W);
  localparam logic [31:0] C_MIN_S   = 32'hFFFF_FFFF << (INT_W - 1);
  localparam logic [7:0]  C_E_SAT_S = 8'(126 + INT_W);
  localparam logic [7:0]  C_E_SAT_U = 8'(127 + INT_W);

  state_t      r_state, w_next;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_m, r_fval;
  logic [5:0]  r_sh, r_cnt;
  logic [7:0]  r_exp;
  logic        r_sign, r_sticky, r_force;
  logic [3:0]  r_fflags;

  logic             w_f2i, w_uns, w_ill, w_s, w_ineg, w_sticky0, w_force, w_al;
  logic [7:0]       w_e;
  logic [22:0]      w_frac;
  logic [55:0]      w_ext;
  logic [5:0]       w_shf;
  logic [INT_W-1:0] w_iraw, w_imag;
  logic [31:0]      w_ld_f, w_ld_i, w_max, w_fval, w_fres, w_ires, w_val;
  logic [3:0]       w_fflags, w_flg;
  logic [23:0]      w_mr;
  logic [7:0]       w_er;
  logic             w_g, w_st, w_up;

  assign w_f2i  = ~r_op[1];
  assign w_uns  = r_op[0];
  assign w_ill  = r_op[2];
  assign w_s    = r_a[31];
  assign w_e    = r_a[30:23];
  assign w_frac = r_a[22:0];

  // F2I: significand pre-scaled so the integer is r_m >> (INT_W-1-unbiased_exp)
  assign w_ext     = {1'b1, w_frac, 32'h0};
  assign w_sticky0 = |w_ext[55-INT_W:0];
  assign w_shf     = 6'(C_E_SAT_S - w_e);
  always_comb begin
    w_ld_f = '0;
    w_ld_f[INT_W-1:0] = w_ext[55 -: INT_W];
  end

  assign w_iraw = r_a[INT_W-1:0];
  assign w_ineg = ~w_uns & w_iraw[INT_W-1];
  assign w_imag = w_ineg ? -w_iraw : w_iraw;
  assign w_ld_i = 32'(w_imag) << (32 - INT_W);
  assign w_max  = w_uns ? C_MAX_U : C_MAX_S;

  // Operands whose result needs no shifting are resolved at unpack time.
  always_comb begin
    w_force  = 1'b0;
    w_fval   = '0;
    w_fflags = '0;
    if (w_f2i) begin
      if (w_e == 8'hFF && w_frac != '0) begin
        w_force = 1'b1; w_fval = w_max; w_fflags = 4'b1000;
      end else if (w_uns && w_s && w_e >= 8'd127) begin
        w_force = 1'b1; w_fflags = 4'b1000;
      end else if (w_e >= (w_uns ? C_E_SAT_U : C_E_SAT_S)) begin
        w_force = 1'b1; w_fflags = 4'b0100;
        w_fval  = (w_s && !w_uns) ? C_MIN_S : w_max;
      end else if (w_e < 8'd127) begin
        w_force = 1'b1; w_fflags = {3'b000, (w_e != '0) || (w_frac != '0)};
      end
    end else if (w_imag == '0) begin
      w_force = 1'b1;
    end
  end

  assign w_al = r_force | (w_f2i ? (r_sh == '0) : r_m[31]);

  assign w_g    = r_m[7];
  assign w_st   = |r_m[6:0];
  assign w_up   = w_g & (w_st | r_m[8]);
  assign w_mr   = {1'b0, r_m[30:8]} + 24'(w_up);
  assign w_er   = r_exp + 8'(w_mr[23]);
  assign w_ires = {r_sign, w_er, w_mr[22:0]};
  assign w_fres = r_sign ? -r_m : r_m;

  always_comb begin
    w_val = r_force ? r_fval : (w_f2i ? w_fres : w_ires);
    w_flg = r_force ? r_fflags : {3'b000, w_f2i ? r_sticky : (w_g | w_st)};
    if (w_f2i ? (w_val == '0) : (w_val[30:0] == '0)) w_flg[1] = 1'b1;
  end

`ifdef FPU_CVT_EARLY_EN
  logic w_al_ld, w_al_nx;
  assign w_al_ld = w_force | (w_f2i ? (w_shf == '0) : w_ld_i[31]);
  assign w_al_nx = w_al | (w_f2i ? (r_sh == 6'd1) : r_m[30]);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_CAPT;
      S_CAPT: begin
        if (w_ill) w_next = S_DONE;
`ifdef FPU_CVT_EARLY_EN
        else if (w_al_ld) w_next = S_RND;
`endif
        else w_next = S_SHIFT;
      end
      S_SHIFT: begin
`ifdef FPU_CVT_EARLY_EN
        if (w_al_nx) w_next = S_RND;
`else
        if (r_cnt == '0) w_next = S_RND;
`endif
      end
      S_RND:   w_next = S_DONE;
      S_DONE:  if (!start) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign o_busy  = (r_state == S_CAPT) || (r_state == S_SHIFT) || (r_state == S_RND);
  assign o_valid = (r_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op <= '0; r_a <= '0; r_m <= '0; r_fval <= '0; r_sh <= '0; r_cnt <= '0;
      r_exp <= '0; r_sign <= 1'b0; r_sticky <= 1'b0; r_force <= 1'b0; r_fflags <= '0;
      o_err <= 1'b0; o_result <= '0; o_flags <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_op <= i_op;
          r_a  <= i_a;
        end
        S_CAPT: begin
          o_result <= '0;
          o_flags  <= '0;
          o_err    <= w_ill;
          r_m      <= w_f2i ? w_ld_f : w_ld_i;
          r_sh     <= w_shf;
          r_cnt    <= 6'(INT_W - 1);
          r_exp    <= C_E_SAT_S;
          r_sign   <= w_f2i ? w_s : w_ineg;
          r_sticky <= w_sticky0;
          r_force  <= w_force;
          r_fval   <= w_fval;
          r_fflags <= w_fflags;
        end
        S_SHIFT: begin
          r_cnt <= r_cnt - 6'd1;
          if (!w_al) begin
            if (w_f2i) begin
              r_m      <= r_m >> 1;
              r_sticky <= r_sticky | r_m[0];
              r_sh     <= r_sh - 6'd1;
            end else begin
              r_m   <= r_m << 1;
              r_exp <= r_exp - 8'd1;
            end
          end
        end
        S_RND: begin
          o_result <= w_val;
          o_flags  <= w_flg;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_cvt_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_fpu_cvt_seq : scoreboard bench with a real/integer arithmetic reference. |
// | Revision       : 1.0                                                        |
// +-----------------------------------------------------------------------------+
module tb_fpu_cvt_seq;
  localparam int INT_W = 32;

  logic        clk, rst, start;
  logic [2:0]  i_op;
  logic [31:0] i_a;
  logic        o_busy, o_valid, o_err;
  logic [31:0] o_result;
  logic [3:0]  o_flags;

  fpu_cvt_seq #(.INT_W(INT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .i_op(i_op), .i_a(i_a),
    .o_busy(o_busy), .o_valid(o_valid), .o_err(o_err),
    .o_result(o_result), .o_flags(o_flags)
  );

  typedef struct {
    logic        err;
    logic [31:0] res;
    logic [3:0]  flg;
    int          t0;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [31:0] a, output exp_t e);
    real    x, t, lim;
    longint v, maxv, minv, raw, mag, qq, rem, half;
    int     p, sh, ex;
    logic   sg, nv, of, nx;
    e.err = 1'b0; e.res = '0; e.flg = '0; e.t0 = 0;
    nv = 1'b0; of = 1'b0; nx = 1'b0; v = 0;
    if (op > 3'd3) begin
      e.err = 1'b1;
    end else if (op < 3'd2) begin
      ex   = int'(a[30:23]);
      maxv = (op == 3'd0) ? (longint'(1) << (INT_W-1)) - 1 : (longint'(1) << INT_W) - 1;
      minv = -(longint'(1) << (INT_W-1));
      lim  = (op == 3'd0) ? 2.0 ** (INT_W-1) : 2.0 ** INT_W;
      if (ex == 255 && a[22:0] != 0) begin
        v = maxv; nv = 1'b1;
      end else begin
        if (ex == 255)     x = 1.0e300;
        else if (ex == 0)  x = real'(a[22:0]) * 2.0 ** (-149);
        else               x = (8388608.0 + real'(a[22:0])) * 2.0 ** (ex - 150);
        if (a[31]) x = -x;
        if (op == 3'd1 && x <= -1.0) begin
          v = 0; nv = 1'b1;
        end else if (x >= lim || -x >= lim) begin
          of = 1'b1; v = (x < 0.0) ? minv : maxv;
        end else begin
          t  = (x < 0.0) ? $ceil(x) : $floor(x);
          v  = longint'(t);
          nx = (t != x);
        end
      end
      e.res = v[31:0];
      e.flg = {nv, of, v == 0, nx};
    end else begin
      raw = longint'(a) & ((longint'(1) << INT_W) - 1);
      v   = (op == 3'd2 && raw[INT_W-1]) ? raw - (longint'(1) << INT_W) : raw;
      sg  = (v < 0);
      mag = sg ? -v : v;
      if (mag == 0) begin
        e.flg = 4'b0010;
      end else begin
        p = 0;
        for (int i = 0; i < 40; i++) if (mag[i]) p = i;
        rem = 0;
        if (p <= 23) begin
          qq = mag << (23 - p);
        end else begin
          sh   = p - 23;
          qq   = mag >> sh;
          rem  = mag - (qq << sh);
          half = longint'(1) << (sh - 1);
          if (rem > half || (rem == half && qq[0])) qq++;
          if (qq == (longint'(1) << 24)) begin qq = qq >> 1; p++; end
        end
        e.res = {sg, 8'(127 + p), qq[22:0]};
        e.flg = {3'b000, rem != 0};
      end
    end
  endtask

  // Called one step after an edge with the DUT idle; returns one step after E0 with start still high.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input bit track);
    exp_t e;
    model(op, a, e);
    start = 1'b1; i_op = op; i_a = a;
    @(posedge clk); #1;
    e.t0 = cyc;
    if (track) q.push_back(e);
    chk("busy_after_start", 64'(o_busy), 64'd1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!o_valid && n < INT_W + 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_valid) begin
      n_tests++; n_fail++;
      $display("FAIL valid_timeout: o_valid 0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a);
    issue(op, a, 1'b1);
    start = 1'b0;
    wait_valid();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: pops one expectation per rising o_valid.
  initial begin
    logic pv;
    exp_t e;
    int   lat;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (o_valid && !pv) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_valid: result %0h with no pending request", o_result);
        end else begin
          e   = q.pop_front();
          lat = cyc - e.t0;
          chk("result", 64'(o_result), 64'(e.res));
          chk("flags", 64'(o_flags), 64'(e.flg));
          chk("err", 64'(o_err), 64'(e.err));
          chk("busy_at_valid", 64'(o_busy), 64'd0);
`ifdef FPU_CVT_EARLY_EN
          if (e.err) chk("latency", 64'(lat), 64'd1);
          else       chk("latency_range", 64'(lat >= 2 && lat <= INT_W + 2), 64'd1);
`else
          chk("latency", 64'(lat), e.err ? 64'd1 : 64'(INT_W + 2));
`endif
        end
      end
      pv = o_valid;
    end
  end

  logic [2:0]  d_op [14];
  logic [31:0] d_a  [14];

  initial begin
    rst = 1'b1; start = 1'b0; i_op = '0; i_a = '0;
    repeat (2) @(posedge clk); #1;
    chk("reset_outputs", 64'({o_busy, o_valid, o_err, o_flags, o_result}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    d_op = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd2,
             3'd0, 3'd0, 3'd1, 3'd2};
    d_a  = '{32'h3FC00000, 32'h41500000, 32'hC3489999, 32'h7FC00000, 32'hC1400000,
             32'hFFFFFFF4, 32'h0007D214, 32'h00000000, 32'hFFFFFFFF, 32'h80000000,
             32'hCF000000, 32'h7F800000, 32'hBF000000, 32'h01000001};
    for (int i = 0; i < 14; i++) run_op(d_op[i], d_a[i]);

    // Illegal op held in DONE, then a legal op clears o_err one edge after acceptance.
    issue(3'd5, 32'h12345678, 1'b1);
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("held_valid", 64'({o_valid, o_busy}), 64'b10);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("valid_dropped", 64'(o_valid), 64'd0);
    issue(3'd0, 32'h41500000, 1'b1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("err_cleared", 64'({o_err, o_result}), 64'd0);
    wait_valid();
    @(posedge clk); #1;

    // Asynchronous reset while parked in DONE with a nonzero result.
    issue(3'd2, 32'hFFFFFFF4, 1'b1);
    wait_valid();
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("async_reset_done", 64'({o_busy, o_valid, o_err, o_flags, o_result}), 64'd0);
    #1 rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    // Reset aborting a conversion at E0+10.
    issue(3'd0, 32'h41500000, 1'b0);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1; #1;
    chk("async_reset_abort", 64'({o_busy, o_valid, o_err, o_flags, o_result}), 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_op(3'd0, 32'h41500000);

    for (int n = 0; n < 250; n++) begin
      logic [2:0]  op;
      logic [31:0] a;
      int          r, ex;
      r  = int'($urandom_range(0, 99));
      op = (r < 5) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      if (op < 3'd2) begin
        r = int'($urandom_range(0, 99));
        if (r < 8)       ex = 0;
        else if (r < 14) ex = 255;
        else             ex = int'($urandom_range(100, 165));
        a = {1'($urandom), 8'(ex), 23'($urandom)};
        if (ex == 255 && $urandom_range(0, 1) == 1) a[22:0] = '0;
      end else begin
        a = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) a = -a;
      end
      run_op(op, a);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
